// File: rtl/mod_n_counter_pkg.sv
// Shared constants and parameter-legality check for the cascaded mod-N counter.
// Optional feature macro: MOD_N_COUNTER_DOWN_EN (adds up/down counting).
package mod_n_counter_pkg;

  localparam int DEF_DIGIT_W = 4;
  localparam int DEF_MODULUS = 10;
  localparam int DEF_DIGITS  = 2;
  localparam int MAX_DIGITS  = 8;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Evaluated at elaboration; every digit value must be representable in DIGIT_W bits.
  function automatic bit params_legal(input int digit_w, input int modulus, input int digits);
    if (digit_w < 1 || digit_w > 30) return 1'b0;
    if (modulus < 2 || modulus > (1 << digit_w)) return 1'b0;
    if (digits < 1 || digits > MAX_DIGITS) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One mod-N digit: synchronous load with out-of-range clamp, single step, terminal flag.
// Down counting is only built when MOD_N_COUNTER_DOWN_EN is defined.
module mod_n_digit
  import mod_n_counter_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               step,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] value,
  output logic               at_term
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] load_clamped;
  logic [DIGIT_W-1:0] stepped;
  logic [DIGIT_W-1:0] value_nxt;

  assign load_clamped = (load_val > MAX_V) ? '0 : load_val;

`ifdef MOD_N_COUNTER_DOWN_EN
  always_comb begin
    stepped = value;
    if (dir == UP) begin
      stepped = (value == MAX_V) ? '0 : value + 1'b1;
    end else begin
      stepped = (value == '0) ? MAX_V : value - 1'b1;
    end
  end

  assign at_term = (dir == UP) ? (value == MAX_V) : (value == '0);
`else
  logic unused_dir;
  assign unused_dir = dir;

  assign stepped = (value == MAX_V) ? '0 : value + 1'b1;
  assign at_term = (value == MAX_V);
`endif

  // Load wins over step; with neither the digit holds.
  always_comb begin
    value_nxt = value;
    if (load) begin
      value_nxt = load_clamped;
    end else if (step) begin
      value_nxt = stepped;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      value <= '0;
    end else begin
      value <= value_nxt;
    end
  end

endmodule

// File: rtl/mod_n_counter.sv
// Synchronous (ripple-free) cascade of DIGITS mod-MODULUS digits with terminal-count output.
// MOD_N_COUNTER_DOWN_EN adds the up_dn port and down counting.
module mod_n_counter
  import mod_n_counter_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int MODULUS = DEF_MODULUS,
  parameter int DIGITS  = DEF_DIGITS
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       en,
  input  logic                       load,
  input  logic [DIGITS*DIGIT_W-1:0]  load_val,
`ifdef MOD_N_COUNTER_DOWN_EN
  input  logic                       up_dn,
`endif
  output logic [DIGITS*DIGIT_W-1:0]  q,
  output logic                       tc
);

  generate
    if (!params_legal(DIGIT_W, MODULUS, DIGITS)) begin : g_illegal_params
      $error("mod_n_counter: illegal DIGIT_W/MODULUS/DIGITS combination");
    end
  endgenerate

  logic              dir;
  logic [DIGITS-1:0] at_term;
  // carry[k] is high when every digit below k sits at its terminal value.
  logic [DIGITS:0]   carry;

`ifdef MOD_N_COUNTER_DOWN_EN
  assign dir = up_dn;
`else
  assign dir = UP;
`endif

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    mod_n_digit #(
      .DIGIT_W (DIGIT_W),
      .MODULUS (MODULUS)
    ) u_digit (
      .clk      (clk),
      .clear    (clear),
      .step     (en & carry[g]),
      .dir      (dir),
      .load     (load),
      .load_val (load_val[g*DIGIT_W +: DIGIT_W]),
      .value    (q[g*DIGIT_W +: DIGIT_W]),
      .at_term  (at_term[g])
    );

    assign carry[g+1] = carry[g] & at_term[g];
  end

  // Gated by clear: in down mode the reset value 0 is itself terminal.
  assign tc = clear & en & ~load & carry[DIGITS];

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter: directed cases plus randomized traffic against
// an integer-count reference model; a second instance covers MODULUS=6/DIGIT_W=3/DIGITS=3.
module tb_mod_n_counter;

`ifdef MOD_N_COUNTER_DOWN_EN
  localparam bit DOWN_BUILD = 1'b1;
`else
  localparam bit DOWN_BUILD = 1'b0;
`endif

  localparam int M = 10, W = 4, D = 2;
  localparam int AM = 6, AW = 3, AD = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear, en, load;
  logic [7:0] load_val;
  logic [7:0] q;
  logic       tc;
`ifdef MOD_N_COUNTER_DOWN_EN
  logic       up_dn;
`endif

  logic       a_clear, a_en, a_load;
  logic [8:0] a_load_val;
  logic [8:0] a_q;
  logic       a_tc;

  mod_n_counter dut (
    .clk      (clk),
    .clear    (clear),
    .en       (en),
    .load     (load),
    .load_val (load_val),
`ifdef MOD_N_COUNTER_DOWN_EN
    .up_dn    (up_dn),
`endif
    .q        (q),
    .tc       (tc)
  );

  mod_n_counter #(.DIGIT_W(AW), .MODULUS(AM), .DIGITS(AD)) dut_alt (
    .clk      (clk),
    .clear    (a_clear),
    .en       (a_en),
    .load     (a_load),
    .load_val (a_load_val),
`ifdef MOD_N_COUNTER_DOWN_EN
    .up_dn    (1'b1),
`endif
    .q        (a_q),
    .tc       (a_tc)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  longint m_cnt = 0;   // whole counter as one integer in 0 .. M**D-1

  function automatic longint ipow(input int b, input int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic logic [31:0] enc(input longint cnt, input int m, input int w, input int d);
    logic [31:0] r = '0;
    longint c = cnt;
    for (int i = 0; i < d; i++) begin
      r = r | (32'(c % m) << (i * w));
      c = c / m;
    end
    return r;
  endfunction

  function automatic longint dec_load(input logic [31:0] lv, input int m, input int w, input int d);
    longint r = 0;
    for (int i = 0; i < d; i++) begin
      longint f = longint'((lv >> (i * w)) & ((32'd1 << w) - 1));
      if (f >= m) f = 0;
      r = r + f * ipow(m, i);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; applies inputs, checks tc, then checks q after the edge.
  task automatic step(input string tag, input logic e, input logic l, input logic [7:0] lv, input logic d);
    logic   up;
    longint n;
    n  = ipow(M, D);
    up = DOWN_BUILD ? d : 1'b1;
    en = e; load = l; load_val = lv;
`ifdef MOD_N_COUNTER_DOWN_EN
    up_dn = d;
`endif
    #1;
    check({tag, "_tc"}, 32'(tc), 32'(e && !l && (up ? (m_cnt == n - 1) : (m_cnt == 0))));
    if (l)      m_cnt = dec_load(32'(lv), M, W, D);
    else if (e) m_cnt = up ? (m_cnt + 1) % n : (m_cnt + n - 1) % n;
    exp_q.push_back(enc(m_cnt, M, W, D));
    @(posedge clk); #1;
    check({tag, "_q"}, 32'(q), exp_q.pop_front());
  endtask

  task automatic pulse_clear(input string tag);
    #2 clear = 1'b0;
    #1;
    check({tag, "_q"}, 32'(q), 32'h0);
    check({tag, "_tc"}, 32'(tc), 32'h0);
    m_cnt = 0;
    #1 clear = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    clear = 1'b0; en = 1'b0; load = 1'b0; load_val = '0;
`ifdef MOD_N_COUNTER_DOWN_EN
    up_dn = 1'b1;
`endif
    a_clear = 1'b0; a_en = 1'b0; a_load = 1'b0; a_load_val = '0;
    #3;
    check("reset_q", 32'(q), 32'h0);
    check("reset_tc", 32'(tc), 32'h0);
    check("reset_alt_q", 32'(a_q), 32'h0);
    @(posedge clk); #1;
    clear = 1'b1; a_clear = 1'b1;

    // Async clear from 0x57 while counting
    step("ld57", 1'b0, 1'b1, 8'h57, 1'b1);
    check("ld57_const", 32'(q), 32'h57);
    en = 1'b1; load = 1'b0;
`ifdef MOD_N_COUNTER_DOWN_EN
    up_dn = 1'b0;
`endif
    pulse_clear("clr57");

    // Up wrap 98 -> 99 (tc) -> 00
    step("ld98", 1'b0, 1'b1, 8'h98, 1'b1);
    step("up99", 1'b1, 1'b0, 8'h00, 1'b1);
    check("up99_const", 32'(q), 32'h99);
    step("up00", 1'b1, 1'b0, 8'h00, 1'b1);
    check("up00_const", 32'(q), 32'h00);

    // Load priority over en, with clamp
    step("ld3c", 1'b1, 1'b1, 8'h3C, 1'b1);
    check("ld3c_const", 32'(q), 32'h30);
    step("ld42", 1'b1, 1'b1, 8'h42, 1'b1);
    check("ld42_const", 32'(q), 32'h42);
    step("ldff", 1'b1, 1'b1, 8'hFF, 1'b1);

    // Hold for 5 edges
    step("ld71", 1'b0, 1'b1, 8'h71, 1'b1);
    for (int i = 0; i < 5; i++) step("hold", 1'b0, 1'b0, 8'hA5, 1'b1);
    check("hold_const", 32'(q), 32'h71);
    step("run", 1'b1, 1'b0, 8'h00, 1'b1);
    pulse_clear("clr_mid");

    // Clear across an edge while load is requested, then normal priority
    en = 1'b1; load = 1'b1; load_val = 8'h42;
    #2 clear = 1'b0;
    @(posedge clk); #1;
    check("clr_load_q", 32'(q), 32'h0);
    check("clr_load_tc", 32'(tc), 32'h0);
    m_cnt = 0;
    clear = 1'b1;
    step("post_clr", 1'b1, 1'b1, 8'h42, 1'b1);
    check("post_clr_const", 32'(q), 32'h42);

`ifdef MOD_N_COUNTER_DOWN_EN
    step("ld10", 1'b1, 1'b1, 8'h10, 1'b0);
    step("dn09", 1'b1, 1'b0, 8'h00, 1'b0);
    check("dn09_const", 32'(q), 32'h09);
    step("dn08", 1'b1, 1'b0, 8'h00, 1'b0);
    check("dn08_const", 32'(q), 32'h08);
    step("ld00", 1'b1, 1'b1, 8'h00, 1'b0);
    step("dn99", 1'b1, 1'b0, 8'h00, 1'b0);
    check("dn99_const", 32'(q), 32'h99);
`endif

    // Randomized traffic, including direction flips and occasional async clears
    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 49) == 0) pulse_clear("rnd_clr");
    end

    // Alternate parameters: 216-state up count
    a_en = 1'b1;
    for (int i = 1; i <= 216; i++) begin
      if (i == 216) check("alt_tc", 32'(a_tc), 32'h1);
      @(posedge clk); #1;
      exp_q.push_back(enc(longint'(i % 216), AM, AW, AD));
      check("alt_q", 32'(a_q), exp_q.pop_front());
      if (i == 215) check("alt_555", 32'(a_q), 32'o555);
      if (i == 216) check("alt_wrap", 32'(a_q), 32'h0);
    end
    a_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
